// File: rtl/pwm_ramp_controller_pkg.sv
// Shared types and helpers for the PWM ramp controller.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

  // Limit a requested duty to a full period (100% on).
  function automatic int clamp_duty(input int duty, input int period);
    return (duty > period) ? period : duty;
  endfunction

  // Classify a channel by comparing applied duty against its target.
  function automatic ramp_state_e ramp_state(input int current, input int target);
    if (current < target) begin
      return RAMP_UP;
    end else if (current > target) begin
      return RAMP_DOWN;
    end else begin
      return HOLD;
    end
  endfunction

  // One ramp step toward target. Arithmetic is done on int, so the
  // intermediate sum/difference can never wrap at the duty width.
  function automatic int ramp_step(input int current, input int target, input int step);
    if (current < target) begin
      return ((current + step) > target) ? target : (current + step);
    end else if (current > target) begin
      return ((current - step) < target) ? target : (current - step);
    end else begin
      return current;
    end
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Configuration write port: host-side master, controller-side slave.
interface pwm_ramp_controller_if #(
  parameter int CHW = 2,
  parameter int CW  = 8
) ();
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_duty;

  modport master (output cfg_valid, output cfg_ch, output cfg_duty, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_ramp_controller_channel.sv
// One PWM channel: target/applied duty registers, ramp sequencer and
// the registered compare output.
module pwm_ramp_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int CW     = 8,
  parameter int PERIOD = 100,
  parameter int STEP   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] cnt_i,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_duty_i,
  input  logic          update_i,
  output logic          pwm_o,
  output logic          busy_o
);

  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] current_q, current_d;
  logic          pwm_q, pwm_d;
  ramp_state_e   state_s;

  // Next-state: host writes replace the target, ramp moves applied duty at period end
  always_comb begin
    state_s   = ramp_state(int'(current_q), int'(target_q));
    target_d  = target_q;
    current_d = current_q;
    if (wr_en_i) begin
      target_d = CW'(clamp_duty(int'(wr_duty_i), PERIOD));
    end else begin
      target_d = target_q;
    end
    if (update_i) begin
      case (state_s)
        HOLD:               current_d = current_q;
        RAMP_UP, RAMP_DOWN: current_d = CW'(ramp_step(int'(current_q), int'(target_q), STEP));
        default:            current_d = current_q;
      endcase
    end else begin
      current_d = current_q;
    end
    // Compare against the duty in force now; a new duty lands at counter 0.
    pwm_d = enable && (cnt_i < current_q);
  end

  // Channel state and compare flop, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q  <= '0;
      current_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign busy_o = (current_q != target_q);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Multi-channel PWM with a shared period counter and per-channel soft ramp.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int PERIOD = 100,
  parameter int CW     = 8,
  parameter int STEP   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  pwm_ramp_controller_if.slave    cfg,
  output logic [NCH-1:0]          pwm,
  output logic                    period_start,
  output logic                    busy
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ps_q, ps_d;
  logic           at_end_s;
  logic           ch_ok_s;
  logic           wr_fire_s;
  logic [NCH-1:0] pwm_s;
  logic [NCH-1:0] busy_s;

  assign at_end_s      = enable && (cnt_q == CW'(PERIOD - 1));
  // The ramp-update cycle is the only cycle a write could race the ramp.
  assign cfg.cfg_ready = !reset && !at_end_s;
  assign wr_fire_s     = cfg.cfg_valid && cfg.cfg_ready && ch_ok_s;

  // Only an index field wide enough to exceed NCH needs a range check.
  if ((1 << CHW) > NCH) begin : g_ch_chk
    assign ch_ok_s = (int'(cfg.cfg_ch) < NCH);
  end else begin : g_ch_all
    assign ch_ok_s = 1'b1;
  end

  // Counter and period marker next-state
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (at_end_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    ps_d = enable && (cnt_q == '0);
  end

  // Period counter and period_start flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_ramp_channel #(
      .CW    (CW),
      .PERIOD(PERIOD),
      .STEP  (STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .cnt_i    (cnt_q),
      .wr_en_i  (wr_fire_s && (cfg.cfg_ch == CHW'(i))),
      .wr_duty_i(cfg.cfg_duty),
      .update_i (at_end_s),
      .pwm_o    (pwm_s[i]),
      .busy_o   (busy_s[i])
    );
  end

  assign pwm          = pwm_s;
  assign period_start = ps_q;
  assign busy         = |busy_s;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// a per-cycle behavioural model of the controller.
module tb_pwm_ramp_controller;
  localparam int NCH = 4;
  localparam int P   = 100;
  localparam int CW  = 8;
  localparam int STP = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [NCH-1:0] pwm;
  logic           period_start;
  logic           busy;

  pwm_ramp_controller_if #(.CHW(2), .CW(CW)) cfg ();

  pwm_ramp_controller #(.NCH(NCH), .PERIOD(P), .CW(CW), .STEP(STP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg(cfg),
    .pwm(pwm), .period_start(period_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int             pc;          // counter value the DUT holds right now
  int             m_tgt[NCH];
  int             m_cur[NCH];
  logic [NCH-1:0] exp_pwm;
  logic           exp_ps;
  logic           exp_busy;

  task automatic model_reset();
    pc = 0;
    for (int i = 0; i < NCH; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
  endtask

  // advance one clock; model computes what the edge should produce
  task automatic step();
    int ch;
    ch = int'(cfg.cfg_ch);
    for (int i = 0; i < NCH; i++) exp_pwm[i] = enable && (pc < m_cur[i]);
    exp_ps = enable && (pc == 0);
    if (cfg.cfg_valid && !(enable && pc == P - 1) && ch < NCH)
      m_tgt[ch] = (int'(cfg.cfg_duty) > P) ? P : int'(cfg.cfg_duty);
    if (enable && pc == P - 1) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_cur[i] < m_tgt[i]) m_cur[i] = (m_cur[i] + STP > m_tgt[i]) ? m_tgt[i] : m_cur[i] + STP;
        else if (m_cur[i] > m_tgt[i]) m_cur[i] = (m_cur[i] - STP < m_tgt[i]) ? m_tgt[i] : m_cur[i] - STP;
      end
    end
    pc = enable ? ((pc == P - 1) ? 0 : pc + 1) : 0;
    @(posedge clk);
    #1;
    exp_busy = 1'b0;
    for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) exp_busy = 1'b1;
  endtask

  task automatic align();
    while (pc != 0) step();
  endtask

  task automatic write(input int ch, input int duty);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'(ch);
    cfg.cfg_duty  = 8'(duty);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = 2'd0; cfg.cfg_duty = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pwm !== 4'b0 || period_start !== 1'b0 || busy !== 1'b0 || cfg.cfg_ready !== 1'b0)
      $display("FAIL reset_state: pwm=%b ps=%b busy=%b ready=%b expected all 0", pwm, period_start, busy, cfg.cfg_ready);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (cfg.cfg_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", cfg.cfg_ready);
    else n_pass++;
  endtask

  task automatic test_ramp_up();
    int hi0, hioth, nps;
    enable = 1'b1;
    write(0, 50);
    step();
    cfg.cfg_valid = 1'b0;
    repeat (P - 1) step();
    for (int p = 1; p <= 5; p++) begin
      hi0 = 0; hioth = 0; nps = 0;
      for (int j = 0; j < P; j++) begin
        step();
        if (pwm[0]) hi0++;
        if (pwm[3:1] != 3'b0) hioth++;
        if (period_start) nps++;
        if (j == 0) begin
          n_checks++;
          if (period_start !== 1'b1) $display("FAIL ramp_up_ps p%0d: got %b expected 1", p, period_start);
          else n_pass++;
        end
      end
      n_checks++;
      if (hi0 != 10 * p || hioth != 0 || nps != 1)
        $display("FAIL ramp_up p%0d: high=%0d others=%0d ps=%0d expected %0d/0/1", p, hi0, hioth, nps, 10 * p);
      else n_pass++;
      n_checks++;
      if (busy !== (p < 4)) $display("FAIL ramp_up_busy p%0d: got %b expected %b", p, busy, (p < 4));
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    int hi;
    write(1, 150);
    step();
    cfg.cfg_valid = 1'b0;
    repeat (10 * P - 1) step();
    hi = 0;
    for (int j = 0; j <= P; j++) begin
      step();
      if (pwm[1]) hi++;
    end
    n_checks++;
    if (hi != P + 1) $display("FAIL clamp_full_on: high=%0d expected %0d", hi, P + 1);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL clamp_busy: got %b expected 0", busy);
    else n_pass++;
    align();
  endtask

  task automatic test_ramp_down();
    int hi;
    int exp_hi[5] = '{50, 40, 30, 35, 35};
    for (int p = 0; p < 5; p++) begin
      hi = 0;
      for (int j = 0; j < P; j++) begin
        if (j == 0 && p == 0) write(0, 25);
        if (j == 0 && p == 2) write(0, 35);
        step();
        cfg.cfg_valid = 1'b0;
        if (pwm[0]) hi++;
      end
      n_checks++;
      if (hi != exp_hi[p]) $display("FAIL ramp_down p%0d: high=%0d expected %0d", p, hi, exp_hi[p]);
      else n_pass++;
    end
  endtask

  task automatic test_blocked();
    repeat (P - 1) step();
    write(2, 7);
    #1;
    n_checks++;
    if (cfg.cfg_ready !== 1'b0) $display("FAIL blocked_ready: got %b expected 0", cfg.cfg_ready);
    else n_pass++;
    step();
    n_checks++;
    if (cfg.cfg_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL blocked_not_taken: ready=%b busy=%b expected 1/0", cfg.cfg_ready, busy);
    else n_pass++;
    step();
    cfg.cfg_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL blocked_taken_at_0: busy=%b expected 1", busy);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int hi, bad;
    write(0, 60);
    step();
    cfg.cfg_valid = 1'b0;
    align();
    repeat (2 * P) step();
    repeat (40) step();
    n_checks++;
    if (pwm[0] !== 1'b1) $display("FAIL drop_pre: pwm0=%b expected 1", pwm[0]);
    else n_pass++;
    enable = 1'b0;
    step();
    n_checks++;
    if (pwm !== 4'b0) $display("FAIL drop_pwm: got %b expected 0000", pwm);
    else n_pass++;
    write(3, 20);
    step();
    cfg.cfg_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (pwm != 4'b0 || period_start) bad++;
    end
    n_checks++;
    if (bad != 0 || busy !== 1'b1) $display("FAIL disabled_hold: bad=%0d busy=%b expected 0/1", bad, busy);
    else n_pass++;
    enable = 1'b1;
    step();
    n_checks++;
    if (period_start !== 1'b1) $display("FAIL reenable_ps: got %b expected 1", period_start);
    else n_pass++;
    hi = pwm[0] ? 1 : 0;
    repeat (P - 1) begin
      step();
      if (pwm[0]) hi++;
    end
    n_checks++;
    if (hi != 60) $display("FAIL reenable_duty: high=%0d expected 60", hi);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      enable        = ($urandom_range(0, 39) != 0);
      cfg.cfg_valid = ($urandom_range(0, 2) == 0);
      cfg.cfg_ch    = 2'($urandom_range(0, NCH - 1));
      cfg.cfg_duty  = 8'($urandom_range(0, 255));
      #1;
      n_checks++;
      if (cfg.cfg_ready !== !(enable && pc == P - 1))
        $display("FAIL rand_ready k%0d: got %b expected %b", k, cfg.cfg_ready, !(enable && pc == P - 1));
      else n_pass++;
      step();
      n_checks++;
      if (pwm !== exp_pwm || period_start !== exp_ps || busy !== exp_busy)
        $display("FAIL rand_out k%0d: pwm=%b ps=%b busy=%b expected %b/%b/%b", k, pwm, period_start, busy, exp_pwm, exp_ps, exp_busy);
      else n_pass++;
    end
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    int bad;
    enable = 1'b1;
    write(2, 90);
    step();
    cfg.cfg_valid = 1'b0;
    repeat (150) step();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL areset_pre_busy: got %b expected 1", busy);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (pwm !== 4'b0 || busy !== 1'b0 || cfg.cfg_ready !== 1'b0)
      $display("FAIL areset_immediate: pwm=%b busy=%b ready=%b expected 0", pwm, busy, cfg.cfg_ready);
    else n_pass++;
    model_reset();
    #2;
    reset = 1'b0;
    bad = 0;
    repeat (2 * P) begin
      step();
      if (pwm != 4'b0 || busy) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL areset_after: nonzero cycles=%0d expected 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_ramp_down();
    test_blocked();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
